// File: rtl/pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pc_sequencer_pkg
// Shared definitions for the program-counter sequencer and its helpers.
//   - seqState_t        : sequencer state encoding (2 bits)
//   - DEFAULT_*         : default widths and reset vector
//   - BC_FLAG_*         : branch-condition flag indices used by branch_decision
//   - flushLoad()       : converts a flush slot count into the counter preload
// -----------------------------------------------------------------------------
package pc_sequencer_pkg;

  // Sequencer states. The encoding is fixed so debug tools can decode it.
  typedef enum logic [1:0] {
    SEQ_BOOT  = 2'd0,
    SEQ_RUN   = 2'd1,
    SEQ_FLUSH = 2'd2,
    SEQ_HALT  = 2'd3
  } seqState_t;

  localparam int DEFAULT_PC_WIDTH     = 8;
  localparam int DEFAULT_RESET_VECTOR = 0;

  // The flush down-counter only ever needs to hold FLUSH_CYCLES-1 (max 14).
  localparam int FLUSH_CTR_WIDTH = 4;

  // Branch-condition flag indices shared with branch_decision.
  localparam int BC_FLAG_EQ    = 0;
  localparam int BC_FLAG_LT    = 1;
  localparam int BC_FLAG_LTU   = 2;
  localparam int BC_FLAG_COUNT = 3;

  // The counter counts down to zero inclusive, so N slots need a preload of N-1.
  function automatic logic [FLUSH_CTR_WIDTH-1:0] flushLoad(input int cycles);
    return FLUSH_CTR_WIDTH'(cycles - 1);
  endfunction

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Generic saturating up-counter with synchronous clear. Used for the
// taken-branch counter and reusable for other performance counters.
//   clk      in   clock
//   rst      in   synchronous active-high reset, clears the count
//   i_clear  in   synchronous clear
//   i_inc    in   increment request; ignored once the count is all-ones
//   o_count  out  current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;
  logic             w_saturated;

  assign w_saturated = (r_count == {WIDTH{1'b1}});

  // Count up on request, stop at all-ones so the value never wraps.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_inc && !w_saturated) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Owns the program counter and sequences fetch around control-flow changes:
// advance, redirect (followed by a squash window), halt and resume.
//   clk           in   clock
//   rst           in   synchronous active-high reset
//   stall         in   freezes pc and sequencing (does not block resume)
//   branch_valid  in   a control-flow instruction resolves this cycle
//   pc_sel        in   branch taken, qualified by branch_valid
//   target_addr   in   redirect address
//   halt_req      in   level request to stop fetch
//   resume        in   pulse that leaves HALT
//   pc            out  current fetch address
//   fetch_valid   out  fetch may issue at pc (state RUN)
//   flush         out  squash IF/ID (state FLUSH)
//   halted        out  sequencer is in HALT
//   taken_cnt     out  saturating count of taken branches
// -----------------------------------------------------------------------------
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                  PC_WIDTH     = DEFAULT_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(DEFAULT_RESET_VECTOR),
  parameter int                  FLUSH_CYCLES = 2,
  parameter int                  CNT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 branch_valid,
  input  logic                 pc_sel,
  input  logic [PC_WIDTH-1:0]  target_addr,
  input  logic                 halt_req,
  input  logic                 resume,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 fetch_valid,
  output logic                 flush,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] taken_cnt
);

  seqState_t                  r_state;
  logic [PC_WIDTH-1:0]        r_pc;
  logic [FLUSH_CTR_WIDTH-1:0] r_flushCtr;
  logic                       r_fetchValid;
  logic                       r_flush;
  logic                       r_halted;

  seqState_t                  w_nextState;
  logic [PC_WIDTH-1:0]        w_nextPc;
  logic [FLUSH_CTR_WIDTH-1:0] w_nextFlushCtr;
  logic                       w_takenInc;
  logic                       w_taken;

  assign w_taken = branch_valid && pc_sel;

  // Next-state decode. A taken branch outranks halt_req; because halt_req is
  // a held level, a halt that loses to a branch is picked up once the flush
  // window drains back to RUN.
  always_comb begin
    w_nextState    = r_state;
    w_nextPc       = r_pc;
    w_nextFlushCtr = r_flushCtr;
    w_takenInc     = 1'b0;
    case (r_state)
      SEQ_BOOT: begin
        w_nextState = SEQ_RUN;
      end
      SEQ_RUN: begin
        if (!stall) begin
          if (w_taken) begin
            w_nextPc       = target_addr;
            w_nextState    = SEQ_FLUSH;
            w_nextFlushCtr = flushLoad(FLUSH_CYCLES);
            w_takenInc     = 1'b1;
          end else if (halt_req) begin
            w_nextState = SEQ_HALT;
          end else begin
            w_nextPc = r_pc + PC_WIDTH'(1);
          end
        end
      end
      SEQ_FLUSH: begin
        if (!stall) begin
          if (r_flushCtr == '0) begin
            w_nextState = SEQ_RUN;
          end else begin
            w_nextFlushCtr = r_flushCtr - FLUSH_CTR_WIDTH'(1);
          end
        end
      end
      SEQ_HALT: begin
        if (resume) begin
          w_nextState = SEQ_RUN;
        end
      end
      default: begin
        w_nextState = SEQ_BOOT;
      end
    endcase
  end

  // State, pc and the Moore outputs are registered together; the outputs are
  // decoded from the state being loaded so they always match r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= SEQ_BOOT;
      r_pc         <= RESET_VECTOR;
      r_flushCtr   <= '0;
      r_fetchValid <= 1'b0;
      r_flush      <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_pc         <= w_nextPc;
      r_flushCtr   <= w_nextFlushCtr;
      r_fetchValid <= (w_nextState == SEQ_RUN);
      r_flush      <= (w_nextState == SEQ_FLUSH);
      r_halted     <= (w_nextState == SEQ_HALT);
    end
  end

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_takenCnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (1'b0),
    .i_inc   (w_takenInc),
    .o_count (taken_cnt)
  );

  assign pc          = r_pc;
  assign fetch_valid = r_fetchValid;
  assign flush       = r_flush;
  assign halted      = r_halted;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the program counter and sequences instruction fetch around control-flow changes. Each cycle it consumes the pc_sel decision from branch_decision together with a resolved target address, then advances, redirects, squashes or halts fetch. It sits between the execute-stage control path and the fetch stage, and keeps a saturating taken-branch counter for debug and performance readout.

Parameters:
PC_WIDTH, 8, width of the program counter and target address.
RESET_VECTOR, 0, PC value loaded on reset.
FLUSH_CYCLES, 2, number of fetch slots squashed after a taken branch. Legal values are 1 to 15.
CNT_WIDTH, 8, width of the taken-branch counter.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
stall  in  1  pipeline stall; freezes PC and sequencing.
branch_valid  in  1  a control-flow instruction resolves this cycle.
pc_sel  in  1  branch/jump taken, from branch_decision; qualified by branch_valid.
target_addr  in  PC_WIDTH  redirect address, valid when branch_valid=1.
halt_req  in  1  request to stop fetch; level, held by the requester until halted=1.
resume  in  1  one-cycle pulse that leaves HALT.
pc  out  PC_WIDTH  current fetch address (registered).
fetch_valid  out  1  fetch stage may issue at pc.
flush  out  1  squash the IF/ID contents.
halted  out  1  sequencer is in HALT.
taken_cnt  out  CNT_WIDTH  count of taken branches, saturating.

Behaviour:
- Reset (rst=1 at an edge): pc=RESET_VECTOR, state=BOOT, flush_ctr=0, taken_cnt=0. Outputs fetch_valid=0, flush=0, halted=0. Reset overrides every other input, including when it arrives mid-FLUSH or mid-HALT.
- Outputs are Moore, decoded from registered state only:
  - fetch_valid = (state==RUN)
  - flush = (state==FLUSH)
  - halted = (state==HALT)
- States: BOOT, RUN, FLUSH, HALT. The encoding lives in the shared header.
- BOOT: lasts exactly one cycle, then goes to RUN. The pc holds at RESET_VECTOR. All inputs are ignored.
- RUN, stall=1: pc, state and counters hold. branch_valid, halt_req and resume are not sampled; upstream must hold them.
- RUN, stall=0, priority from highest to lowest:
  1. Taken branch (branch_valid & pc_sel): pc <= target_addr; state <= FLUSH; flush_ctr <= FLUSH_CYCLES-1; taken_cnt <= taken_cnt+1, saturating at all-ones.
  2. halt_req: pc holds; state <= HALT. halt_req in the same cycle as a taken branch is deferred until the sequencer is back in RUN.
  3. Otherwise, including a not-taken branch: pc <= pc+1, modulo 2^PC_WIDTH, so all-ones wraps to 0.
- FLUSH: pc holds at the branch target. Each cycle with stall=0, flush_ctr decrements. When flush_ctr==0 with stall=0, state goes to RUN. This gives exactly FLUSH_CYCLES cycles with flush=1 when there is no stall. stall extends FLUSH. branch_valid and halt_req are ignored.
- HALT: pc holds. resume=1 moves to RUN on the next edge, and the next fetch is at the held pc. stall does not block resume. branch_valid is ignored.
- taken_cnt: never wraps. It is cleared only by rst.
- Latency: redirect is one cycle. The edge that samples a taken branch loads pc; fetch_valid is 0 for FLUSH_CYCLES cycles and then 1 with pc=target.

Decomposition:
- Shared header param.vh holds:
  - the state encodings (SEQ_BOOT, SEQ_RUN, SEQ_FLUSH, SEQ_HALT, 2 bits);
  - the default PC_WIDTH and RESET_VECTOR;
  - the existing BC flag indices.
- Sub-module sat_counter, parameterised width with increment and sync clear, implements taken_cnt and is reusable for other performance counters.
- flush_ctr and the FSM stay inline.

Test Plan:
- Reset then free-run, stall=0, no branches: cycle 0 BOOT with pc=0x00 and fetch_valid=0. Then pc=0x00, 0x01, 0x02 … with fetch_valid=1 and flush=0 throughout.
- PC_WIDTH=8, run from RESET_VECTOR=0xFE: pc goes 0xFE, 0xFF, 0x00, confirming wrap with no glitch on fetch_valid.
- Taken branch at pc=0x10, branch_valid=1, pc_sel=1, target_addr=0x40, FLUSH_CYCLES=2: next two cycles pc=0x40, flush=1, fetch_valid=0; third cycle fetch_valid=1, pc=0x40, taken_cnt=1. Not-taken (pc_sel=0) at 0x10 gives pc=0x11 and no flush.
- stall=1 during RUN with branch_valid=1: pc and taken_cnt frozen. Deassert stall: redirect happens then. stall=1 for 3 cycles inside FLUSH: flush stays high for 2+3=5 cycles.
- Taken branch and halt_req in the same cycle: goes FLUSH to RUN to HALT. halted=1 with pc=target. A resume pulse gives fetch_valid=1 with pc unchanged. rst asserted mid-FLUSH gives BOOT, pc=RESET_VECTOR, taken_cnt=0 at the next edge.
- Force 300 taken branches: taken_cnt saturates at 0xFF and stays there.
